uart_receiver: RTL

Serial-to-parallel UART receiver, 8N1, LSB first. It consumes the line driven by the team's UART transmitter, or the PC's TX line. It recovers bytes using a per-frame bit-period counter and presents each byte on a valid/ack handshake. It flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_receiver_if.sv | 17 +
 rtl/uart_rx_sync.sv | 48 ++++
 rtl/uart_receiver.sv | 131 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// frame size and the standard baud divisors for a 12 MHz clock.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam int DATA_BITS = 8;
   localparam int B9600     = 1250;
   localparam int B115200   = 104;

endpackage

// File: rtl/uart_receiver_if.sv
// Bundle of the serial line and the consumer-side byte handshake.
// slave  : the receiver (takes rx/ack, drives the byte and status flags)
// master : whatever drives the line and consumes bytes
interface uart_receiver_if;
   import uart_pkg::*;

   logic                 rx;
   logic                 ack;
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 overrun;
   logic                 ferr;
   logic                 busy;

   modport master (output rx, ack, input data, valid, overrun, ferr, busy);
   modport slave  (input rx, ack, output data, valid, overrun, ferr, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Input conditioning for the serial line: 2-flop synchronizer, falling
// edge detect and the sample value used at each bit sample point.
// Build option UART_RX_MAJORITY_EN: sample value becomes the majority of
// the last three synchronized samples, rejecting single-cycle glitches.
module uart_rx_sync (
   input  logic clk,
   input  logic rstn,
   input  logic rx_i,
   output logic rx_s_o,
   output logic fall_o,
   output logic rx_vote_o
);

   logic meta_q;
   logic rx_s_q;
   logic prev_q;

   // Synchronize the line and keep its previous value; all flops idle high
   always_ff @(posedge clk) begin
      if (!rstn) begin
         meta_q <= 1'b1;
         rx_s_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         rx_s_q <= meta_q;
         prev_q <= rx_s_q;
      end
   end

   assign rx_s_o = rx_s_q;
   assign fall_o = prev_q & ~rx_s_q;

`ifdef UART_RX_MAJORITY_EN
   logic prev2_q;

   // Third history tap for the 2-of-3 vote
   always_ff @(posedge clk) begin
      if (!rstn) prev2_q <= 1'b1;
      else       prev2_q <= prev_q;
   end

   assign rx_vote_o = (rx_s_q & prev_q) | (rx_s_q & prev2_q) | (prev_q & prev2_q);
`else
   assign rx_vote_o = rx_s_q;
`endif

endmodule

// File: rtl/uart_receiver.sv
// 8N1 LSB-first UART receiver with a valid/ack byte handshake, sticky
// overrun flag and single-cycle framing-error pulse.
// Build option UART_RX_MAJORITY_EN (see uart_rx_sync) selects majority
// voting at every sample point.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int BAUD = B9600
) (
   input logic            clk,
   input logic            rstn,
   uart_receiver_if.slave bus
);

   localparam int CW = $clog2(BAUD);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF_CNT = CW'(BAUD / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(BAUD - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   logic rx_s;
   logic fall;
   logic rx_vote;

   uart_rx_sync u_sync (
      .clk       (clk),
      .rstn      (rstn),
      .rx_i      (bus.rx),
      .rx_s_o    (rx_s),
      .fall_o    (fall),
      .rx_vote_o (rx_vote)
   );

   uart_state_e          state_q,   state_d;
   logic [CW-1:0]        cnt_q,     cnt_d;
   logic [BW-1:0]        bitc_q,    bitc_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic [DATA_BITS-1:0] data_q,    data_d;
   logic                 valid_q,   valid_d;
   logic                 overrun_q, overrun_d;
   logic                 ferr_q,    ferr_d;

   // State and output registers; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bitc_q    <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bitc_q    <= bitc_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   // Frame sequencing, bit sampling and handshake; a byte published in the
   // same cycle as ack overrides the ack
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      bitc_d    = bitc_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      ferr_d    = 1'b0;

      if (bus.ack && valid_q) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            // fall already implies rx_s low; a held-low line never qualifies
            if (fall && !rx_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_CNT) begin
               cnt_d = '0;
               if (rx_vote) begin
                  state_d = IDLE;
               end else begin
                  bitc_d  = '0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               shift_d = {rx_vote, shift_q[DATA_BITS-1:1]};
               bitc_d  = bitc_q + 1'b1;
               if (bitc_q == LAST_BIT) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == FULL_CNT) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (rx_vote) begin
                  data_d    = shift_q;
                  valid_d   = 1'b1;
                  overrun_d = valid_q && !bus.ack;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.data    = data_q;
   assign bus.valid   = valid_q;
   assign bus.overrun = overrun_q;
   assign bus.ferr    = ferr_q;
   assign bus.busy    = (state_q != IDLE);

endmodule
